// File: rtl/shift_add_mult_seq.sv
// shift_add_mult_seq: sequential unsigned shift-add multiplier with valid/ready handshakes
module shift_add_mult_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    logic [1:0]         state;
    logic [WIDTH-1:0]   a_r, b_r;
    logic [2*WIDTH-1:0] acc, acc_nxt;
    logic [CNT_W-1:0]   j;
    logic               last;
    // Partial product is formed at full product width so no shifted bit is lost.
    always_comb begin
        acc_nxt = a_r[j] ? acc + ({{WIDTH{1'b0}}, b_r} << j) : acc;
        last    = j == CNT_W'(WIDTH - 1);
    end
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_r     <= '0;
            b_r     <= '0;
            acc     <= '0;
            j       <= '0;
            product <= '0;
        end else if (state == IDLE) begin
            if (in_valid) begin
                a_r   <= a;
                b_r   <= b;
                acc   <= '0;
                j     <= '0;
                state <= RUN;
            end
        end else if (state == RUN) begin
            acc <= acc_nxt;
            j   <= last ? '0 : j + CNT_W'(1);
            if (last) begin
                product <= acc_nxt;
                state   <= DONE;
            end
        end else begin
            state <= out_ready ? IDLE : DONE;
        end
    end
endmodule

// File: tb/tb_shift_add_mult_seq.sv
// tb_shift_add_mult_seq: directed and random checks of the shift-add multiplier against a*b
module tb_shift_add_mult_seq;
    localparam int WIDTH = 8;
    localparam int CNT_W = 3;
    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               out_ready = 1'b0;
    logic [WIDTH-1:0]   a = '0;
    logic [WIDTH-1:0]   b = '0;
    logic               in_ready, out_valid, busy;
    logic [2*WIDTH-1:0] product;
    int n_assert = 0;
    int n_fail = 0;

    shift_add_mult_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One full transaction: accept, fixed-latency wait, optional backpressure, release.
    task automatic txn(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                       input int hold, input bit ff_junk);
        logic [2*WIDTH-1:0] exp;
        exp = (2*WIDTH)'(ta) * (2*WIDTH)'(tb_v);
        @(negedge clk);
        in_valid = 1'b1; a = ta; b = tb_v; out_ready = 1'b0;
        check("in_ready_idle", in_ready, 1);
        for (int k = 0; k < WIDTH; k++) begin
            @(negedge clk);
            check("busy_run", busy, 1);
            check("in_ready_run", in_ready, 0);
            check("out_valid_run", out_valid, 0);
            in_valid  = ff_junk ? 1'b1 : 1'($urandom);
            a         = ff_junk ? '1 : WIDTH'($urandom);
            b         = ff_junk ? '1 : WIDTH'($urandom);
            out_ready = 1'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        check("out_valid_done", out_valid, 1);
        check("product", product, exp);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("out_valid_hold", out_valid, 1);
            check("product_hold", product, exp);
            check("in_ready_hold", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_drop", out_valid, 0);
        check("in_ready_back", in_ready, 1);
        check("busy_idle", busy, 0);
        check("product_kept", product, exp);
    endtask

    initial begin
        int t0, t1, nout;
        logic [2*WIDTH-1:0] p1, p2;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_product", product, 0);
        rst_n = 1'b1;
        txn(8'd13, 8'd11, 0, 1'b0);
        txn(8'd255, 8'd255, 0, 1'b0);
        txn(8'd0, 8'd200, 0, 1'b0);
        txn(8'd128, 8'd1, 0, 1'b0);
        txn(8'd7, 8'd9, 20, 1'b0);
        txn(8'd3, 8'd5, 0, 1'b1);
        for (int i = 0; i < 12; i++)
            txn(WIDTH'($urandom), WIDTH'($urandom), int'($urandom_range(0, 3)), 1'b0);
        // Abort mid-operation: async reset must clear outputs without waiting for a clock.
        @(negedge clk);
        in_valid = 1'b1; a = 8'd200; b = 8'd100;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_product", product, 0);
        for (int k = 0; k < WIDTH + 2; k++) begin
            @(negedge clk);
            check("abort_no_valid", out_valid, 0);
        end
        rst_n = 1'b1;
        txn(8'd2, 8'd3, 0, 1'b0);
        // Back-to-back with in_valid held high.
        t0 = -1; t1 = -1; nout = 0;
        p1 = 16'd17 * 16'd19;
        p2 = 16'd23 * 16'd29;
        @(negedge clk);
        a = 8'd17; b = 8'd19; in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (t0 >= 0 && k == t0 + 1) begin
                a = 8'd23; b = 8'd29;
            end
            if (t1 >= 0) in_valid = 1'b0;
            if (out_valid) begin
                check("b2b_product", product, nout == 0 ? p1 : p2);
                nout++;
            end
            if (in_ready && in_valid) begin
                if (t0 < 0) t0 = k;
                else if (t1 < 0) t1 = k;
            end
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check("b2b_first_accept", t0, 0);
        check("b2b_spacing", t1 - t0, WIDTH + 2);
        check("b2b_outputs", nout, 2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
